centroid_seq: RTL and testbench

Parametrised, sequential successor to the combinational 8-bin centroid block.
- Takes a C_HIST_BINS-bin column histogram of the inner frame, captured in one cycle on a frame-processed pulse.
- Accumulates the totals and scans the bins with a small FSM, then emits a one-hot (or centred two-hot) centroid, its bin index, and a proximity level.
- Adds lost-object hysteresis: the last valid centroid is held until C_LOST_FRAMES consecutive empty frames have been seen.
- Sits between the colour-filter histogram stage and the robot steering logic.

---
 rtl/centroid_pkg.sv | 29 ++
 rtl/lead_one_det.sv | 22 ++
 rtl/centroid_seq.sv | 199 +++++++++++++++++++
 tb/tb_centroid_seq.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/centroid_pkg.sv
// Shared types and helpers for the sequential centroid block.
package centroid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DECIDE,
    ST_SEARCH,
    ST_OUTPUT
  } state_t;

  // Widest packed histogram the slice helper can address.
  localparam int MAX_VEC = 1024;
  typedef logic [MAX_VEC-1:0] vec_t;

  function automatic logic [31:0] bin_slice(input vec_t vec, input int unsigned k,
                                            input int unsigned w);
    vec_t sh;
    sh = vec >> (k * w);
    return sh[31:0] & ((32'd1 << w) - 32'd1);
  endfunction

  function automatic int sat_clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/lead_one_det.sv
// Leading-one index encoder: idx is the position of the highest set bit of value.
module lead_one_det #(
  parameter int w      = 14,
  parameter int nb_idx = $clog2(w)
) (
  input  logic [w-1:0]      value,
  output logic [nb_idx-1:0] idx,
  output logic              found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < w; i++) begin
      if (value[i]) begin
        idx   = nb_idx'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/centroid_seq.sv
// Sequential histogram centroid: accumulate, decide, search, then publish with
// lost-object hysteresis. Fixed latency of c_hist_bins + c_hist_bins/2 + 2 cycles.
module centroid_seq
  import centroid_pkg::*;
#(
  parameter int c_hist_bins     = 8,
  parameter int c_nb_hist_val   = 10,
  parameter int c_nb_pxls       = 14,
  parameter int c_min_colorpxls = 128,
  parameter int c_center_shift  = 4,
  parameter int c_nb_prox       = 3,
  parameter int c_prox_lsb      = 5,
  parameter int c_lost_frames   = 4,
  parameter int c_nb_idx        = $clog2(c_hist_bins)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   new_frame_proc_i,
  input  logic [c_hist_bins*c_nb_hist_val-1:0]   histogram_i,
  output logic                                   busy_o,
  output logic [c_hist_bins-1:0]                 centroid_o,
  output logic [c_nb_idx-1:0]                    centroid_idx_o,
  output logic                                   detected_o,
  output logic                                   lost_o,
  output logic [c_nb_prox-1:0]                   proximity_o,
  output logic                                   new_centroid_o,
  output logic                                   frame_drop_o
);

  localparam int half_bins = c_hist_bins / 2;
  localparam int max_prox  = (1 << c_nb_prox) - 1;
  localparam int nb_lost   = $clog2(c_lost_frames + 1);
  localparam int nb_lead   = $clog2(c_nb_pxls);
  localparam logic [c_hist_bins-1:0] two_hot = c_hist_bins'(3) << (half_bins - 1);

  typedef logic [c_nb_pxls-1:0] acc_t;

  state_t state_reg, state_next;
  logic [c_nb_hist_val-1:0] bins_reg [c_hist_bins];
  logic [c_nb_idx-1:0] cnt_reg, sel_reg, search_idx, sel_c;
  acc_t total_reg, left_reg, rght_reg, half_reg, cum_reg;
  acc_t bin_val, absdif_c, cum_c;
  logic det_reg, is_left_reg, centred_reg, found_reg;
  logic det_c, is_left_c, centred_c, hit_c;
  logic last_accum, last_search, busy;
  logic [nb_lost-1:0] lost_cnt_reg, lost_cnt_inc;
  logic [nb_lead-1:0] lead_idx;
  logic lead_found;
  logic [c_nb_prox-1:0] prox_c;
  vec_t hist_ext;

  logic [c_hist_bins-1:0] centroid_reg;
  logic [c_nb_idx-1:0]    centroid_idx_reg;
  logic [c_nb_prox-1:0]   proximity_reg;
  logic detected_reg, lost_reg, new_centroid_reg, frame_drop_reg;

  assign hist_ext    = vec_t'(histogram_i);
  assign busy        = (state_reg != ST_IDLE);
  assign last_accum  = (cnt_reg == c_nb_idx'(c_hist_bins - 1));
  assign last_search = (cnt_reg == c_nb_idx'(half_bins - 1));

  // SEARCH walks from the outer edge of the heavier side toward the centre.
  assign search_idx = is_left_reg ? cnt_reg : c_nb_idx'(c_hist_bins - 1) - cnt_reg;
  assign bin_val    = acc_t'(bins_reg[(state_reg == ST_SEARCH) ? search_idx : cnt_reg]);

  assign det_c     = total_reg > acc_t'(c_min_colorpxls);
  assign is_left_c = left_reg > rght_reg;
  assign absdif_c  = is_left_c ? (left_reg - rght_reg) : (rght_reg - left_reg);
  assign centred_c = det_c && (absdif_c < (total_reg >> c_center_shift));

  // Falling through to the innermost bin on the last step covers "never reached half".
  assign cum_c = cum_reg + bin_val;
  assign hit_c = !found_reg && ((cum_c >= half_reg) || last_search);
  assign sel_c = hit_c ? search_idx : sel_reg;

  assign lost_cnt_inc = (lost_cnt_reg == nb_lost'(c_lost_frames)) ?
                        lost_cnt_reg : lost_cnt_reg + nb_lost'(1);

  lead_one_det #(.w(c_nb_pxls), .nb_idx(nb_lead)) u_lead (
    .value (total_reg),
    .idx   (lead_idx),
    .found (lead_found)
  );

  assign prox_c = lead_found ?
                  c_nb_prox'(sat_clamp(int'(lead_idx) - c_prox_lsb + 1, 0, max_prox)) : '0;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (new_frame_proc_i) state_next = ST_ACCUM;
      ST_ACCUM:  if (last_accum) state_next = ST_DECIDE;
      ST_DECIDE: state_next = ST_SEARCH;
      ST_SEARCH: if (last_search) state_next = ST_OUTPUT;
      ST_OUTPUT: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < c_hist_bins; k++) bins_reg[k] <= '0;
      cnt_reg          <= '0;
      total_reg        <= '0;
      left_reg         <= '0;
      rght_reg         <= '0;
      half_reg         <= '0;
      cum_reg          <= '0;
      sel_reg          <= '0;
      det_reg          <= 1'b0;
      is_left_reg      <= 1'b0;
      centred_reg      <= 1'b0;
      found_reg        <= 1'b0;
      lost_cnt_reg     <= '0;
      centroid_reg     <= '0;
      centroid_idx_reg <= '0;
      proximity_reg    <= '0;
      detected_reg     <= 1'b0;
      lost_reg         <= 1'b0;
      new_centroid_reg <= 1'b0;
      frame_drop_reg   <= 1'b0;
    end else begin
      frame_drop_reg   <= new_frame_proc_i && busy;
      new_centroid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: if (new_frame_proc_i) begin
          for (int k = 0; k < c_hist_bins; k++)
            bins_reg[k] <= c_nb_hist_val'(bin_slice(hist_ext, k, c_nb_hist_val));
          total_reg <= '0;
          left_reg  <= '0;
          rght_reg  <= '0;
          cnt_reg   <= '0;
        end
        ST_ACCUM: begin
          total_reg <= total_reg + bin_val;
          if (cnt_reg < c_nb_idx'(half_bins)) left_reg <= left_reg + bin_val;
          else                                rght_reg <= rght_reg + bin_val;
          cnt_reg <= last_accum ? '0 : cnt_reg + c_nb_idx'(1);
        end
        ST_DECIDE: begin
          det_reg     <= det_c;
          is_left_reg <= is_left_c;
          centred_reg <= centred_c;
          half_reg    <= total_reg >> 1;
          cum_reg     <= '0;
          found_reg   <= 1'b0;
          sel_reg     <= '0;
          cnt_reg     <= '0;
        end
        ST_SEARCH: begin
          cum_reg <= cum_c;
          sel_reg <= sel_c;
          if (hit_c) found_reg <= 1'b1;
          cnt_reg <= last_search ? '0 : cnt_reg + c_nb_idx'(1);
          // Results land as the FSM enters OUTPUT so new_centroid_o marks that cycle.
          if (last_search) begin
            new_centroid_reg <= 1'b1;
            detected_reg     <= det_reg;
            proximity_reg    <= prox_c;
            if (det_reg) begin
              lost_cnt_reg <= '0;
              lost_reg     <= 1'b0;
              if (centred_reg) begin
                centroid_reg     <= two_hot;
                centroid_idx_reg <= c_nb_idx'(half_bins - 1);
              end else begin
                centroid_reg     <= c_hist_bins'(1) << sel_c;
                centroid_idx_reg <= sel_c;
              end
            end else begin
              lost_cnt_reg <= lost_cnt_inc;
              if (lost_cnt_inc == nb_lost'(c_lost_frames)) begin
                lost_reg         <= 1'b1;
                centroid_reg     <= '0;
                centroid_idx_reg <= '0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o         = busy;
  assign centroid_o     = centroid_reg;
  assign centroid_idx_o = centroid_idx_reg;
  assign detected_o     = detected_reg;
  assign lost_o         = lost_reg;
  assign proximity_o    = proximity_reg;
  assign new_centroid_o = new_centroid_reg;
  assign frame_drop_o   = frame_drop_reg;

endmodule

// File: tb/tb_centroid_seq.sv
// Scoreboard bench for centroid_seq: stimulus pushes hand-computed results,
// a negedge monitor pops and compares on every new_centroid_o pulse.
module tb_centroid_seq;

  localparam int LAT = 14;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        new_frame = 1'b0;
  logic [79:0] hist = '0;
  logic        busy, det, lost, new_cen, drop;
  logic [7:0]  cen;
  logic [2:0]  idx, prox;

  centroid_seq dut (
    .clk              (clk),
    .rst              (rst),
    .new_frame_proc_i (new_frame),
    .histogram_i      (hist),
    .busy_o           (busy),
    .centroid_o       (cen),
    .centroid_idx_o   (idx),
    .detected_o       (det),
    .lost_o           (lost),
    .proximity_o      (prox),
    .new_centroid_o   (new_cen),
    .frame_drop_o     (drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] cen;
    logic [2:0] idx;
    logic       det;
    logic       lost;
    logic [2:0] prox;
    int         issue;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

  function automatic logic [79:0] pk(input int b0, input int b1, input int b2, input int b3,
                                     input int b4, input int b5, input int b6, input int b7);
    logic [79:0] v;
    int b [8];
    b = '{b0, b1, b2, b3, b4, b5, b6, b7};
    v = '0;
    for (int k = 0; k < 8; k++) v[k*10 +: 10] = b[k][9:0];
    return v;
  endfunction

  always @(negedge clk) begin
    if (!rst && new_cen) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: new_centroid_o=1 at cycle %0d, required no pulse", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        $display("frame @%0d: centroid=%h idx=%0d det=%b lost=%b prox=%0d busy=%b",
                 cyc, cen, idx, det, lost, prox, busy);
        checks++;
        if ({cen, idx, det, lost, prox} !== {mon_e.cen, mon_e.idx, mon_e.det, mon_e.lost, mon_e.prox}) begin
          errors++;
          $display("FAIL result: got cen=%h idx=%0d det=%b lost=%b prox=%0d, required cen=%h idx=%0d det=%b lost=%b prox=%0d",
                   cen, idx, det, lost, prox, mon_e.cen, mon_e.idx, mon_e.det, mon_e.lost, mon_e.prox);
        end
        checks++;
        if (cyc - mon_e.issue != LAT || busy !== 1'b1) begin
          errors++;
          $display("FAIL latency: got %0d cycles busy=%b, required %0d cycles busy=1",
                   cyc - mon_e.issue, busy, LAT);
        end
      end
    end
  end

  task automatic send(input logic [79:0] h, input logic [7:0] e_cen, input int e_idx,
                      input logic e_det, input logic e_lost, input int e_prox);
    exp_t e;
    @(posedge clk); #1;
    e.cen = e_cen; e.idx = 3'(e_idx); e.det = e_det; e.lost = e_lost;
    e.prox = 3'(e_prox); e.issue = cyc;
    exp_q.push_back(e);
    hist = h;
    new_frame = 1'b1;
    @(posedge clk); #1;
    new_frame = 1'b0;
    hist = '0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL timeout: %0d results still pending, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_frame: busy_o=%b, required 0", busy);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  int base;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {23'd0, busy, cen, idx, det, lost, prox, new_cen, drop}, 32'd0);
    rst = 1'b0;

    send(pk(800, 0, 0, 0, 0, 0, 0, 0), 8'h01, 0, 1, 0, 5);   drain();
    send(pk(0, 0, 0, 300, 300, 0, 0, 0), 8'h18, 3, 1, 0, 5); drain();
    send(pk(0, 0, 0, 0, 0, 200, 250, 100), 8'h40, 6, 1, 0, 5); drain();

    // Hysteresis: hold for three empty frames, lost on the fourth, recover.
    send(pk(800, 0, 0, 0, 0, 0, 0, 0), 8'h01, 0, 1, 0, 5); drain();
    for (int f = 0; f < 3; f++) begin
      send(pk(0, 0, 100, 0, 0, 0, 0, 0), 8'h01, 0, 0, 0, 2); drain();
    end
    send(pk(0, 0, 100, 0, 0, 0, 0, 0), 8'h00, 0, 0, 1, 2); drain();
    send(pk(800, 0, 0, 0, 0, 0, 0, 0), 8'h01, 0, 1, 0, 5); drain();

    // Frame arriving while busy is dropped.
    send(pk(800, 0, 0, 0, 0, 0, 0, 0), 8'h01, 0, 1, 0, 5);
    base = cyc - 1;
    repeat (4) @(posedge clk);
    #1;
    chk("drop_cycle", 32'(cyc - base), 32'd5);
    chk("drop_before", {31'd0, drop}, 32'd0);
    hist = pk(0, 0, 0, 0, 0, 0, 0, 800);
    new_frame = 1'b1;
    @(posedge clk); #1;
    new_frame = 1'b0;
    hist = '0;
    chk("drop_pulse", {31'd0, drop}, 32'd1);
    @(posedge clk); #1;
    chk("drop_once", {31'd0, drop}, 32'd0);
    drain();

    // Reset mid-frame aborts without a result.
    send(pk(0, 0, 0, 300, 300, 0, 0, 0), 8'h18, 3, 1, 0, 5);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_outputs", {23'd0, busy, cen, idx, det, lost, prox, new_cen, drop}, 32'd0);
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("abort_idle", {31'd0, busy}, 32'd0);

    send(pk(0, 0, 0, 0, 0, 200, 250, 100), 8'h40, 6, 1, 0, 5); drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
